// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width, GPR count and the hardwired-zero
// register index.
package cpu_pkg;
  localparam int CPU_DATA_W   = 32;
  localparam int CPU_NUM_REGS = 32;
  localparam int CPU_ADDR_W   = $clog2(CPU_NUM_REGS);
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per GPR plus one for the HI/LO pair.
// Set on issue, clear on writeback; a new producer outranks a retiring one.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NUM_REGS = CPU_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_reg,
  input  logic                issue_hilo,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   write_reg,
  input  logic                hilo_write,
  output logic [NUM_REGS-1:0] pending,
  output logic                pending_hilo
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      pending_hilo <= 1'b0;
    end else begin
      pending[REG_ZERO] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (issue_en && issue_reg == ADDR_W'(i))
          pending[i] <= 1'b1;
        else if (write_en && write_reg == ADDR_W'(i))
          pending[i] <= 1'b0;
      end
      if (issue_hilo)
        pending_hilo <= 1'b1;
      else if (hilo_write)
        pending_hilo <= 1'b0;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// GPR file with HI/LO pair, write-first bypassed read ports, r0 tied to zero,
// and scoreboard-driven operand ready / decode stall.
module register_file_sb
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = CPU_DATA_W,
  parameter  int NUM_REGS = CPU_NUM_REGS,
  parameter  int NUM_READ = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] read_addr,
  output logic [NUM_READ*DATA_W-1:0] read_data,
  output logic [NUM_READ-1:0]        read_ready,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_reg,
  input  logic                       issue_hilo,
  input  logic                       write_en,
  input  logic [ADDR_W-1:0]          write_reg,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       hilo_write,
  input  logic [DATA_W-1:0]          hi_data,
  input  logic [DATA_W-1:0]          lo_data,
  output logic [DATA_W-1:0]          hi_out,
  output logic [DATA_W-1:0]          lo_out,
  output logic                       hilo_ready,
  output logic                       stall
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [NUM_REGS-1:0] w_pend;
  logic                w_pend_hilo;
  logic [NUM_READ-1:0] w_rdy;
  logic                w_wr_ok;

  assign w_wr_ok = write_en && (write_reg != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_wr_ok)
        r_regs[write_reg] <= write_data;
      if (hilo_write) begin
        r_hi <= hi_data;
        r_lo <= lo_data;
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .issue_en     (issue_en),
    .issue_reg    (issue_reg),
    .issue_hilo   (issue_hilo),
    .write_en     (write_en),
    .write_reg    (write_reg),
    .hilo_write   (hilo_write),
    .pending      (w_pend),
    .pending_hilo (w_pend_hilo)
  );

  // Ready uses pre-edge pending state; a same-cycle writeback counts as ready.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    assign w_addr = read_addr[k*ADDR_W +: ADDR_W];
    assign w_hit  = write_en && (write_reg == w_addr);
    assign read_data[k*DATA_W +: DATA_W] =
      (w_addr == ADDR_W'(REG_ZERO)) ? '0 :
      w_hit ? write_data : r_regs[w_addr];
    assign w_rdy[k] = ~w_pend[w_addr] | w_hit;
  end

  assign read_ready = w_rdy;
  assign hi_out     = hilo_write ? hi_data : r_hi;
  assign lo_out     = hilo_write ? lo_data : r_lo;
  assign hilo_ready = ~w_pend_hilo | hilo_write;
  assign stall      = (|(~w_rdy)) | (issue_hilo & ~hilo_ready);

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb (4 read ports): driver pushes model
// predictions into a queue, a negedge monitor pops and compares.
module tb_register_file_sb;

  localparam int NR = 4;

  typedef struct {
    logic [4:0]  ra [NR];
    bit          ien;
    logic [4:0]  ireg;
    bit          ih;
    bit          wen;
    logic [4:0]  wreg;
    logic [31:0] wd;
    bit          hw;
    logic [31:0] hd;
    logic [31:0] ld;
    bit          rst;
  } stim_t;

  typedef struct {
    logic [31:0] rd [NR];
    logic [NR-1:0] rdy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hrdy;
    logic        stall;
  } exp_t;

  logic           clk = 0;
  logic           reset = 1;
  logic [NR*5-1:0]  read_addr = '0;
  logic [NR*32-1:0] read_data;
  logic [NR-1:0]  read_ready;
  logic           issue_en = 0;
  logic [4:0]     issue_reg = '0;
  logic           issue_hilo = 0;
  logic           write_en = 0;
  logic [4:0]     write_reg = '0;
  logic [31:0]    write_data = '0;
  logic           hilo_write = 0;
  logic [31:0]    hi_data = '0;
  logic [31:0]    lo_data = '0;
  logic [31:0]    hi_out;
  logic [31:0]    lo_out;
  logic           hilo_ready;
  logic           stall;

  register_file_sb #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .NUM_READ (NR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_ready (read_ready),
    .issue_en   (issue_en),
    .issue_reg  (issue_reg),
    .issue_hilo (issue_hilo),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .hilo_write (hilo_write),
    .hi_data    (hi_data),
    .lo_data    (lo_data),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .hilo_ready (hilo_ready),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_reg [32];
  bit          m_pend [32];
  logic [31:0] m_hi, m_lo;
  bit          m_ph;

  exp_t q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    for (int k = 0; k < NR; k++) s.ra[k] = '0;
    s.ien = 0; s.ireg = '0; s.ih = 0;
    s.wen = 0; s.wreg = '0; s.wd = '0;
    s.hw = 0; s.hd = '0; s.ld = '0; s.rst = 0;
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 0;
    end
    m_hi = '0; m_lo = '0; m_ph = 0;
  endtask

  // One cycle: drive, predict, push, then advance the model past the edge.
  task automatic cyc(input stim_t s);
    exp_t e;
    bit any_nr;
    @(posedge clk);
    #1;
    reset = s.rst;
    for (int k = 0; k < NR; k++) read_addr[k*5 +: 5] = s.ra[k];
    issue_en = s.ien; issue_reg = s.ireg; issue_hilo = s.ih;
    write_en = s.wen; write_reg = s.wreg; write_data = s.wd;
    hilo_write = s.hw; hi_data = s.hd; lo_data = s.ld;
    if (s.rst) model_clear();
    any_nr = 0;
    for (int k = 0; k < NR; k++) begin
      logic [4:0] a;
      bit hit;
      a = s.ra[k];
      hit = !s.rst && s.wen && s.wreg == a;
      if (a == 0) e.rd[k] = '0;
      else if (hit) e.rd[k] = s.wd;
      else e.rd[k] = m_reg[a];
      e.rdy[k] = !m_pend[a] || hit;
      if (!e.rdy[k]) any_nr = 1;
    end
    e.hi = (!s.rst && s.hw) ? s.hd : m_hi;
    e.lo = (!s.rst && s.hw) ? s.ld : m_lo;
    e.hrdy = !m_ph || (!s.rst && s.hw);
    e.stall = any_nr || (s.ih && !e.hrdy);
    q.push_back(e);
    if (!s.rst) begin
      if (s.wen && s.wreg != 0) m_reg[s.wreg] = s.wd;
      if (s.hw) begin m_hi = s.hd; m_lo = s.ld; end
      if (s.wen) m_pend[s.wreg] = 0;
      if (s.ien && s.ireg != 0) m_pend[s.ireg] = 1;
      if (s.hw) m_ph = 0;
      if (s.ih) m_ph = 1;
      m_pend[0] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int k = 0; k < NR; k++)
        chk($sformatf("read_data%0d", k), read_data[k*32 +: 32], e.rd[k]);
      chk("read_ready", {28'd0, read_ready}, {28'd0, e.rdy});
      chk("hi_out", hi_out, e.hi);
      chk("lo_out", lo_out, e.lo);
      chk("hilo_ready", {31'd0, hilo_ready}, {31'd0, e.hrdy});
      chk("stall", {31'd0, stall}, {31'd0, e.stall});
    end
  end

  initial begin
    stim_t s;
    int guard;
    model_clear();
    s = idle(); s.rst = 1; cyc(s);
    // reset mid-run after r5 write
    s = idle(); s.wen = 1; s.wreg = 5; s.wd = 32'h1234; cyc(s);
    s = idle(); s.ra[0] = 5; cyc(s);
    s = idle(); s.ra[0] = 5; s.rst = 1; cyc(s);
    s = idle(); s.ra[0] = 5; cyc(s);
    // bypass then stored
    s = idle(); s.ra[0] = 3; s.wen = 1; s.wreg = 3; s.wd = 32'hDEADBEEF;
    cyc(s);
    s = idle(); s.ra[0] = 3; cyc(s);
    // r0 writes and issues are ignored
    s = idle(); s.wen = 1; s.wreg = 0; s.wd = 32'hFFFFFFFF;
    s.ien = 1; s.ireg = 0; cyc(s);
    s = idle(); cyc(s);
    // issue r7, wait, writeback
    s = idle(); s.ien = 1; s.ireg = 7; cyc(s);
    s = idle(); s.ra[1] = 7; cyc(s);
    s = idle(); s.ra[1] = 7; s.wen = 1; s.wreg = 7; s.wd = 32'h55; cyc(s);
    s = idle(); s.ra[1] = 7; cyc(s);
    // simultaneous issue and writeback of r9
    s = idle(); s.ien = 1; s.ireg = 9; s.wen = 1; s.wreg = 9;
    s.wd = 32'h99; cyc(s);
    s = idle(); s.ra[0] = 9; cyc(s);
    // HI/LO pending then written; aliasing reads of r2
    s = idle(); s.wen = 1; s.wreg = 2; s.wd = 32'hCAFE0002; cyc(s);
    s = idle(); s.ih = 1; cyc(s);
    s = idle(); s.ih = 1; for (int k = 0; k < NR; k++) s.ra[k] = 2; cyc(s);
    s = idle(); s.hw = 1; s.hd = 32'hA; s.ld = 32'hB;
    for (int k = 0; k < NR; k++) s.ra[k] = 2; cyc(s);
    s = idle(); cyc(s);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      s = idle();
      for (int k = 0; k < NR; k++)
        s.ra[k] = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
      s.ien  = ($urandom_range(0, 3) == 0);
      s.ireg = 5'($urandom_range(0, 7));
      s.ih   = ($urandom_range(0, 5) == 0);
      s.wen  = ($urandom_range(0, 1) == 0);
      s.wreg = 5'($urandom_range(0, 7));
      s.wd   = $urandom;
      s.hw   = ($urandom_range(0, 4) == 0);
      s.hd   = $urandom;
      s.ld   = $urandom;
      if ($urandom_range(0, 99) == 0) s = idle();
      if ($urandom_range(0, 99) == 0) s.rst = 1;
      if (s.rst) begin
        s.wen = 0; s.hw = 0; s.ih = 0; s.ien = 0;
      end
      cyc(s);
    end
    s = idle(); cyc(s);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
